// File: rtl/mvm_job_sequencer.sv
// Host-side job sequencer for the mvm_8_8_20_1 matrix-vector multiplier.
// Holds the host-loaded matrix and vector and streams them into the MVM,
// in either order. It then starts the core, waits for done with a timeout
// and captures the K results into a registered read port.
module mvm_job_sequencer #(
    parameter int K       = 8,
    parameter int B       = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic                   wr_sel,
    input  logic [$clog2(K*K)-1:0] wr_addr,
    input  logic [B-1:0]           wr_data,
    input  logic                   cmd_valid,
    input  logic                   cmd_vec_first,
    output logic                   cmd_ready,
    output logic                   busy,
    output logic                   job_done,
    output logic                   err_timeout,
    input  logic [$clog2(K)-1:0]   rd_addr,
    output logic [2*B-1:0]         rd_data,
    output logic                   mvm_reset,
    output logic                   mvm_loadMatrix,
    output logic                   mvm_loadVector,
    output logic                   mvm_start,
    input  logic                   mvm_done,
    output logic [B-1:0]           mvm_data_in,
    input  logic [2*B-1:0]         mvm_data_out
);
    localparam int MW    = $clog2(K*K);
    localparam int IW    = $clog2(K);
    localparam int CNT_W = $clog2(TIMEOUT + K*K) + 1;

    localparam logic [CNT_W-1:0] MAT_LAST = CNT_W'(K*K - 1);
    localparam logic [CNT_W-1:0] VEC_LAST = CNT_W'(K - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE, MRST, GAP0, PULSE1, STREAM1, GAP1, PULSE2,
        STREAM2, GAP2, START, WAIT, CAPTURE, FINISH
    } state_t;

    state_t state, next_state;

    // cnt restarts at 0 on every state entry; it indexes streams,
    // counts WAIT cycles and selects the result slot in CAPTURE
    logic [CNT_W-1:0] cnt;
    logic             vec_first;
    logic             err;

    logic signed [B-1:0]   mat_buf [K*K];
    logic signed [B-1:0]   vec_buf [K];
    logic signed [2*B-1:0] res_buf [K];

    logic [CNT_W-1:0] first_last, second_last;

    assign first_last  = vec_first ? VEC_LAST : MAT_LAST;
    assign second_last = vec_first ? MAT_LAST : VEC_LAST;

    // state register, phase counter and per-job flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            vec_first <= 1'b0;
            err       <= 1'b0;
        end else begin
            state <= next_state;
            cnt   <= (next_state != state) ? '0 : cnt + CNT_W'(1);
            if (state == IDLE && cmd_valid) begin
                vec_first <= cmd_vec_first;
            end
            if (state == WAIT) begin
                err <= (next_state == FINISH);
            end
        end
    end

    // next-state sequencing and decoded MVM / host outputs
    always_comb begin
        next_state     = state;
        cmd_ready      = 1'b0;
        busy           = (state != IDLE);
        job_done       = 1'b0;
        err_timeout    = 1'b0;
        mvm_reset      = 1'b0;
        mvm_loadMatrix = 1'b0;
        mvm_loadVector = 1'b0;
        mvm_start      = 1'b0;
        mvm_data_in    = '0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) next_state = MRST;
            end
            MRST: begin
                mvm_reset  = 1'b1;
                next_state = GAP0;
            end
            GAP0:   next_state = PULSE1;
            PULSE1: begin
                mvm_loadVector = vec_first;
                mvm_loadMatrix = ~vec_first;
                next_state     = STREAM1;
            end
            STREAM1: begin
                mvm_data_in = vec_first ? vec_buf[cnt[IW-1:0]] : mat_buf[cnt[MW-1:0]];
                if (cnt == first_last) next_state = GAP1;
            end
            GAP1:   next_state = PULSE2;
            PULSE2: begin
                mvm_loadMatrix = vec_first;
                mvm_loadVector = ~vec_first;
                next_state     = STREAM2;
            end
            STREAM2: begin
                mvm_data_in = vec_first ? mat_buf[cnt[MW-1:0]] : vec_buf[cnt[IW-1:0]];
                if (cnt == second_last) next_state = GAP2;
            end
            GAP2:   next_state = START;
            START: begin
                mvm_start  = 1'b1;
                next_state = WAIT;
            end
            WAIT: begin
                // done is only honoured here, so a level left over from a
                // previous run cannot end the job before start
                if (mvm_done) next_state = CAPTURE;
                else if (cnt == TO_LAST) next_state = FINISH;
            end
            CAPTURE: begin
                if (cnt == VEC_LAST) next_state = FINISH;
            end
            FINISH: begin
                job_done    = 1'b1;
                err_timeout = err;
                next_state  = IDLE;
            end
            default: next_state = IDLE;
        endcase
        // while reset is held the core is kept in reset and everything else is quiet
        if (reset) begin
            cmd_ready      = 1'b0;
            busy           = 1'b0;
            job_done       = 1'b0;
            err_timeout    = 1'b0;
            mvm_reset      = 1'b1;
            mvm_loadMatrix = 1'b0;
            mvm_loadVector = 1'b0;
            mvm_start      = 1'b0;
            mvm_data_in    = '0;
        end
    end

    // operand buffers: host writes land only while idle, including the accept cycle
    always_ff @(posedge clk) begin
        if (wr_en && state == IDLE && !reset) begin
            if (wr_sel) vec_buf[wr_addr[IW-1:0]] <= wr_data;
            else        mat_buf[wr_addr]         <= wr_data;
        end
    end

    // result buffer capture and registered read port
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < K; i++) res_buf[i] <= '0;
            rd_data <= '0;
        end else begin
            if (state == CAPTURE) res_buf[cnt[IW-1:0]] <= mvm_data_out;
            rd_data <= res_buf[rd_addr];
        end
    end

endmodule

// File: tb/tb_mvm_job_sequencer.sv
// Bench for mvm_job_sequencer: a behavioural MVM model answers the load and
// start protocol; expected results are queued per job and compared on readback.
module tb_mvm_job_sequencer;
    localparam int K = 8;
    localparam int B = 8;
    localparam int TIMEOUT = 1024;

    logic        clk = 1'b0;
    logic        reset, wr_en, wr_sel, cmd_valid, cmd_vec_first;
    logic [5:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        cmd_ready, busy, job_done, err_timeout;
    logic [2:0]  rd_addr;
    logic [15:0] rd_data;
    logic        mvm_reset, mvm_loadMatrix, mvm_loadVector, mvm_start;
    logic        mvm_done = 1'b0;
    logic [7:0]  mvm_data_in;
    logic [15:0] mvm_data_out = '0;

    int checks = 0;
    int failures = 0;

    logic signed [7:0] tb_mat [64];
    logic signed [7:0] tb_vec [8];
    logic [15:0]       last_res [8];
    logic [15:0]       exp_q [$];

    // behavioural MVM state
    logic signed [7:0] m_mat [64];
    logic signed [7:0] m_vec [8];
    logic [15:0]       m_res [8];
    int  m_mode = 0, m_idx = 0, m_cnt = 0, out_idx = -1;
    bit  m_running = 1'b0;
    bit  done_never = 1'b0;
    int  done_delay = 20;

    always #5 clk = ~clk;

    mvm_job_sequencer #(.K(K), .B(B), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_addr(wr_addr), .wr_data(wr_data), .cmd_valid(cmd_valid),
        .cmd_vec_first(cmd_vec_first), .cmd_ready(cmd_ready), .busy(busy),
        .job_done(job_done), .err_timeout(err_timeout), .rd_addr(rd_addr),
        .rd_data(rd_data), .mvm_reset(mvm_reset), .mvm_loadMatrix(mvm_loadMatrix),
        .mvm_loadVector(mvm_loadVector), .mvm_start(mvm_start), .mvm_done(mvm_done),
        .mvm_data_in(mvm_data_in), .mvm_data_out(mvm_data_out)
    );

    // MVM model: loads follow their pulse, done comes done_delay cycles after
    // start, results follow done one per cycle
    always @(posedge clk) begin
        mvm_done     <= 1'b0;
        mvm_data_out <= '0;
        if (mvm_reset) begin
            m_mode = 0; m_running = 1'b0; out_idx = -1;
        end else begin
            if (m_mode == 1) begin
                m_mat[m_idx] = mvm_data_in; m_idx++;
                if (m_idx == 64) m_mode = 0;
            end else if (m_mode == 2) begin
                m_vec[m_idx] = mvm_data_in; m_idx++;
                if (m_idx == 8) m_mode = 0;
            end
            if (mvm_loadMatrix) begin m_mode = 1; m_idx = 0; end
            if (mvm_loadVector) begin m_mode = 2; m_idx = 0; end
            if (out_idx >= 0) begin
                mvm_data_out <= m_res[out_idx];
                out_idx = (out_idx == 7) ? -1 : out_idx + 1;
            end
            if (mvm_start) begin
                m_running = 1'b1; m_cnt = 0;
            end else if (m_running) begin
                m_cnt++;
                if (m_cnt == done_delay - 1 && !done_never) begin
                    mvm_done <= 1'b1;
                    m_running = 1'b0;
                    for (int i = 0; i < 8; i++) begin
                        int acc;
                        acc = 0;
                        for (int j = 0; j < 8; j++) acc += int'(m_mat[i*8+j]) * int'(m_vec[j]);
                        m_res[i] = acc[15:0];
                    end
                    out_idx = 0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic push_buffers();
        for (int i = 0; i < 64; i++) begin
            @(negedge clk); wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 6'(i); wr_data = tb_mat[i];
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); wr_en = 1'b1; wr_sel = 1'b1; wr_addr = 6'(i); wr_data = tb_vec[i];
        end
        @(negedge clk); wr_en = 1'b0;
    endtask

    task automatic push_expected(input bit keep_old);
        for (int i = 0; i < 8; i++) begin
            int acc;
            if (!keep_old) begin
                acc = 0;
                for (int j = 0; j < 8; j++) acc += int'(tb_mat[i*8+j]) * int'(tb_vec[j]);
                last_res[i] = acc[15:0];
            end
            exp_q.push_back(last_res[i]);
        end
    endtask

    task automatic readback(input string tag);
        logic [15:0] e;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); rd_addr = 3'(i);
            @(negedge clk);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
            chk($sformatf("%s_res[%0d]", tag, i), rd_data, e);
        end
    endtask

    task automatic run_job(input string tag, input bit vf, input bit hold, input bit exp_to,
                           input bit acc_wr, input int acc_addr, input logic [7:0] acc_data,
                           input bit junk, input int abort_at);
        int n, t_lm, t_lv, t_st, t_d, t_jd, overlap;
        bit e;
        t_lm = -1; t_lv = -1; t_st = -1; t_d = -1; t_jd = -1; overlap = 0; e = 1'b0;
        @(negedge clk);
        chk({tag, "_ready0"}, cmd_ready, 1);
        cmd_valid = 1'b1; cmd_vec_first = vf;
        if (acc_wr) begin
            wr_en = 1'b1; wr_sel = 1'b1; wr_addr = 6'(acc_addr); wr_data = acc_data;
            tb_vec[acc_addr] = acc_data;
        end
        if (abort_at == 0) push_expected(exp_to);
        @(negedge clk); n = 1;
        wr_en = 1'b0;
        if (!hold) cmd_valid = 1'b0;
        chk({tag, "_ready_busy1"}, {cmd_ready, busy}, 2'b01);
        while (n < 1500) begin
            if (junk && n >= 10 && n < 20) begin
                wr_en = 1'b1; wr_sel = n[0]; wr_addr = 6'(n); wr_data = 8'd55;
            end else begin
                wr_en = 1'b0;
            end
            if (mvm_loadMatrix && t_lm < 0) t_lm = n;
            if (mvm_loadVector && t_lv < 0) t_lv = n;
            if (mvm_start && t_st < 0) t_st = n;
            if (mvm_done && t_st >= 0 && t_d < 0) t_d = n;
            if (int'(mvm_loadMatrix) + int'(mvm_loadVector) + int'(mvm_start) > 1) overlap++;
            if (job_done) begin t_jd = n; e = err_timeout; break; end
            if (n == abort_at) break;
            @(negedge clk); n++;
        end
        wr_en = 1'b0;
        if (abort_at != 0) begin
            reset = 1'b1;
            @(negedge clk);
            chk({tag, "_rst_mvm_reset"}, mvm_reset, 1);
            chk({tag, "_rst_strobes"}, {mvm_loadMatrix, mvm_loadVector, mvm_start}, 0);
            chk({tag, "_rst_data_in"}, mvm_data_in, 0);
            chk({tag, "_rst_job_done"}, job_done, 0);
            @(negedge clk);
            chk({tag, "_rst_job_done2"}, job_done, 0);
            reset = 1'b0;
            @(negedge clk);
            chk({tag, "_ready_after_rst"}, {cmd_ready, busy}, 2'b10);
            return;
        end
        if (t_jd < 0) chk({tag, "_job_done_seen"}, job_done, 1);
        chk({tag, "_t_loadMatrix"}, t_lm, vf ? 13 : 3);
        chk({tag, "_t_loadVector"}, t_lv, vf ? 3 : 69);
        chk({tag, "_t_start"}, t_st, 79);
        chk({tag, "_strobe_overlap"}, overlap, 0);
        if (exp_to) begin
            chk({tag, "_t_job_done"}, t_jd, t_st + TIMEOUT + 1);
            chk({tag, "_err_timeout"}, e, 1);
        end else begin
            chk({tag, "_t_done"}, t_d, t_st + done_delay);
            chk({tag, "_t_job_done"}, t_jd, t_d + K + 1);
            chk({tag, "_err_timeout"}, e, 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
        cmd_valid = 1'b0; cmd_vec_first = 1'b0; rd_addr = '0;
        repeat (2) @(negedge clk);
        chk("reset_mvm_reset", mvm_reset, 1);
        chk("reset_outputs", {cmd_ready, busy, job_done, err_timeout, mvm_start}, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", cmd_ready, 1);
        for (int i = 0; i < 8; i++) last_res[i] = '0;
        push_expected(1'b1);
        readback("reset_clear");

        // identity matrix, x = 1..8, both stream orders
        for (int i = 0; i < 64; i++) tb_mat[i] = (i / 8 == i % 8) ? 8'sd1 : 8'sd0;
        for (int i = 0; i < 8; i++) tb_vec[i] = 8'(i + 1);
        push_buffers();
        run_job("ident_mat_first", 1'b0, 1'b0, 1'b0, 1'b0, 0, 8'd0, 1'b0, 0);
        readback("ident_mat_first");
        run_job("ident_vec_first", 1'b1, 1'b0, 1'b0, 1'b0, 0, 8'd0, 1'b0, 0);
        readback("ident_vec_first");

        // most negative operands: 8*16384 wraps to 0
        for (int i = 0; i < 64; i++) tb_mat[i] = -8'sd128;
        for (int i = 0; i < 8; i++) tb_vec[i] = -8'sd128;
        push_buffers();
        run_job("neg_extreme", 1'b0, 1'b0, 1'b0, 1'b0, 0, 8'd0, 1'b0, 0);
        readback("neg_extreme");

        // 127 * -1; last vector element arrives in the accept cycle
        for (int i = 0; i < 64; i++) tb_mat[i] = 8'sd127;
        for (int i = 0; i < 8; i++) tb_vec[i] = (i == 7) ? 8'sd0 : -8'sd1;
        push_buffers();
        run_job("pos_times_neg", 1'b1, 1'b0, 1'b0, 1'b1, 7, 8'hFF, 1'b0, 0);
        readback("pos_times_neg");

        // done never arrives: abort with error, results retained
        done_never = 1'b1;
        run_job("timeout", 1'b0, 1'b0, 1'b1, 1'b0, 0, 8'd0, 1'b0, 0);
        done_never = 1'b0;
        readback("timeout_keep");

        // reset during the second stream, then buffer reads as cleared
        run_job("abort", 1'b0, 1'b0, 1'b0, 1'b0, 0, 8'd0, 1'b0, 72);
        for (int i = 0; i < 8; i++) last_res[i] = '0;
        push_expected(1'b1);
        readback("abort_clear");

        // back-to-back jobs with cmd_valid held and writes attempted while busy
        for (int i = 0; i < 64; i++) tb_mat[i] = (i / 8 == i % 8) ? 8'sd1 : 8'sd0;
        for (int i = 0; i < 8; i++) tb_vec[i] = 8'(i + 1);
        push_buffers();
        run_job("hold_a", 1'b0, 1'b1, 1'b0, 1'b0, 0, 8'd0, 1'b1, 0);
        run_job("hold_b", 1'b0, 1'b0, 1'b0, 1'b0, 0, 8'd0, 1'b0, 0);
        readback("hold_a");
        readback("hold_b");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
